// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: predictor mode encodings, the
// mispredict counter width and the reset value of a table counter.
package bp_pkg;

  // Index formation modes
  localparam int BP_BIMODAL = 0;
  localparam int BP_GSHARE  = 1;

  // Width of the saturating mispredict statistics counter
  localparam int MISP_CNT_W = 16;

  // Weakly-not-taken encoding for a counter of the given width
  // (a 1-bit counter has no "weak" state, so it starts at not-taken).
  function automatic int unsigned ctr_reset_value(input int unsigned ctr_w);
    if (ctr_w <= 1) begin
      return 0;
    end
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one saturating up/down counter: dir=1 counts up,
// dir=0 counts down, and the value sticks at all-ones or zero.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] value,
  input  logic         dir,
  output logic [W-1:0] next_value
);

  // Saturating increment/decrement
  always_comb begin
    // NOTE: default first so every path assigns next_value and no latch is
    // inferred; combinational logic uses blocking assignments throughout.
    next_value = value;
    if (dir) begin
      if (value != '1) begin
        next_value = value + 1'b1;
      end
    end else if (value != '0) begin
      next_value = value - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor. A lookup registers the
// prediction, the table index and the pre-lookup history one cycle later;
// the history is updated speculatively with the predicted bit and repaired
// from the returned snapshot when a mispredicted branch resolves.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 5,
  parameter int MODE    = BP_GSHARE
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic                  lookup_valid,
  input  logic [INDEX_W-1:0]    lookup_pc,
  output logic                  prediction,
  output logic [INDEX_W-1:0]    pred_index,
  output logic [GHR_W-1:0]      pred_ghr,
  input  logic                  update_valid,
  input  logic [INDEX_W-1:0]    update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  input  logic [GHR_W-1:0]      update_ghr,
  output logic [MISP_CNT_W-1:0] mispredict_count
);

  localparam int               ENTRIES  = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_reset_value(CTR_W));

  // Pattern history table: one saturating counter per entry, held in flops
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [GHR_W-1:0]   ghr_q;
  logic [GHR_W-1:0]   ghr_d;
  logic [GHR_W-1:0]   ghr_spec;
  logic [GHR_W-1:0]   ghr_recover;
  logic [INDEX_W-1:0] ghr_ext;
  logic [INDEX_W-1:0] lookup_idx;
  logic               lookup_pred;
  logic [CTR_W-1:0]   upd_cur;
  logic [CTR_W-1:0]   upd_next;
  logic               do_lookup;
  logic               do_update;
  logic               do_recover;
  logic               unused_update_ghr_msb;

  assign do_lookup  = en & lookup_valid;
  assign do_update  = en & update_valid;
  assign do_recover = en & update_valid & update_mispredict;

  // The oldest history bit of the returned snapshot shifts out on recovery
  assign unused_update_ghr_msb = update_ghr[GHR_W-1];

  // Zero-extend history to index width and form the table index
  always_comb begin
    ghr_ext             = '0;
    ghr_ext[GHR_W-1:0]  = ghr_q;
    if (MODE == BP_GSHARE) begin
      lookup_idx = lookup_pc ^ ghr_ext;
    end else begin
      lookup_idx = lookup_pc;
    end
  end

  // Direction is the counter MSB; the table is read before this cycle's
  // update lands, so a same-index lookup sees the old value
  assign lookup_pred = ctr_q[lookup_idx][CTR_W-1];
  assign upd_cur     = ctr_q[update_index];

  sat_counter #(
    .W (CTR_W)
  ) u_sat_counter (
    .value      (upd_cur),
    .dir        (update_taken),
    .next_value (upd_next)
  );

  // Candidate histories: speculative shift and mispredict repair
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_spec    = lookup_pred;
      assign ghr_recover = update_taken;
    end else begin : g_ghr_multi
      assign ghr_spec    = {ghr_q[GHR_W-2:0], lookup_pred};
      assign ghr_recover = {update_ghr[GHR_W-2:0], update_taken};
    end
  endgenerate

  // Next history: repair wins over a same-cycle speculative shift
  always_comb begin
    ghr_d = ghr_q;
    if (do_recover) begin
      ghr_d = ghr_recover;
    end else if (do_lookup) begin
      ghr_d = ghr_spec;
    end
  end

  // Counter table write on resolved branches
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: this table is a flop array, not a RAM, so every entry is reset
    // to a known counter state; a real memory macro could not be reset this way.
    if (arst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (do_update) begin
      ctr_q[update_index] <= upd_next;
    end
  end

  // Registered lookup results, held while no lookup is accepted
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (arst) begin
      prediction <= 1'b0;
      pred_index <= '0;
      pred_ghr   <= '0;
    end else if (do_lookup) begin
      prediction <= lookup_pred;
      pred_index <= lookup_idx;
      pred_ghr   <= ghr_q;
    end
  end

  // Global history register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ghr_q <= '0;
    end else if (en) begin
      ghr_q <= ghr_d;
    end
  end

  // Saturating mispredict statistics counter
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mispredict_count <= '0;
    end else if (do_recover && (mispredict_count != '1)) begin
      mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (INDEX_W=5, CTR_W=2, GHR_W=5,
// MODE=gshare). A behavioural model predicts the outputs of every cycle and
// pushes them to a scoreboard; directed checks pin the documented scenarios.
module tb_gshare_predictor;

  localparam int INDEX_W = 5;
  localparam int CTR_W   = 2;
  localparam int GHR_W   = 5;

  logic               clk;
  logic               arst;
  logic               en;
  logic               lookup_valid;
  logic [INDEX_W-1:0] lookup_pc;
  logic               prediction;
  logic [INDEX_W-1:0] pred_index;
  logic [GHR_W-1:0]   pred_ghr;
  logic               update_valid;
  logic [INDEX_W-1:0] update_index;
  logic               update_taken;
  logic               update_mispredict;
  logic [GHR_W-1:0]   update_ghr;
  logic [15:0]        mispredict_count;

  gshare_predictor #(
    .INDEX_W (INDEX_W),
    .CTR_W   (CTR_W),
    .GHR_W   (GHR_W),
    .MODE    (1)
  ) dut (
    .clk               (clk),
    .arst              (arst),
    .en                (en),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .prediction        (prediction),
    .pred_index        (pred_index),
    .pred_ghr          (pred_ghr),
    .update_valid      (update_valid),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .update_ghr        (update_ghr),
    .mispredict_count  (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic [4:0]  idx;
    logic [4:0]  pghr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0]  m_tab [32];
  logic [4:0]  m_ghr;
  logic        m_pred;
  logic [4:0]  m_idx;
  logic [4:0]  m_pghr;
  logic [15:0] m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_tab[i] = 2'd1;
    m_ghr  = '0;
    m_pred = 1'b0;
    m_idx  = '0;
    m_pghr = '0;
    m_cnt  = '0;
  endtask

  task automatic idle_inputs();
    en                = 1'b0;
    lookup_valid      = 1'b0;
    lookup_pc         = '0;
    update_valid      = 1'b0;
    update_index      = '0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
    update_ghr        = '0;
  endtask

  // One clock of stimulus; model predicts, scoreboard compares after the edge
  task automatic step(input logic e, input logic lv, input logic [4:0] pc,
                      input logic uv, input logic [4:0] ui, input logic ut,
                      input logic um, input logic [4:0] ug);
    logic [4:0] idx;
    logic       dir_bit;
    exp_t       exp_v;
    en = e; lookup_valid = lv; lookup_pc = pc;
    update_valid = uv; update_index = ui; update_taken = ut;
    update_mispredict = um; update_ghr = ug;
    idx     = pc ^ m_ghr;
    dir_bit = m_tab[idx][1];
    if (e) begin
      if (lv) begin
        m_pred = dir_bit;
        m_idx  = idx;
        m_pghr = m_ghr;
      end
      if (uv && um)  m_ghr = {ug[3:0], ut};
      else if (lv)   m_ghr = {m_ghr[3:0], dir_bit};
      if (uv) begin
        if (ut && m_tab[ui] != 2'd3)       m_tab[ui] = m_tab[ui] + 2'd1;
        else if (!ut && m_tab[ui] != 2'd0) m_tab[ui] = m_tab[ui] - 2'd1;
      end
      if (uv && um && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    sb.push_back('{m_pred, m_idx, m_pghr, m_cnt});
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    n_total++;
    if (prediction !== exp_v.pred)
      $display("FAIL sb_prediction: got %b expected %b", prediction, exp_v.pred);
    else n_pass++;
    n_total++;
    if (pred_index !== exp_v.idx)
      $display("FAIL sb_pred_index: got %0d expected %0d", pred_index, exp_v.idx);
    else n_pass++;
    n_total++;
    if (pred_ghr !== exp_v.pghr)
      $display("FAIL sb_pred_ghr: got %b expected %b", pred_ghr, exp_v.pghr);
    else n_pass++;
    n_total++;
    if (mispredict_count !== exp_v.cnt)
      $display("FAIL sb_mispredict_count: got %h expected %h", mispredict_count, exp_v.cnt);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset();
    int bad;
    idle_inputs();
    #2 arst = 1'b1;
    #1;
    n_total++;
    if ({prediction, pred_index, pred_ghr, mispredict_count} !== '0)
      $display("FAIL reset_outputs: got pred=%b idx=%0d ghr=%b cnt=%h expected all zero",
               prediction, pred_index, pred_ghr, mispredict_count);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.ctr_q[i] !== 2'd1) bad++;
    n_total++;
    if (bad != 0) $display("FAIL reset_counters: got %0d entries not 01 expected 0", bad);
    else n_pass++;
    @(posedge clk);
    #1 arst = 1'b0;
    model_reset();
    step(1, 1, 5'd3, 0, 0, 0, 0, 0);
    n_total++;
    if (prediction !== 1'b0 || pred_index !== 5'd3 || pred_ghr !== 5'd0)
      $display("FAIL reset_first_lookup: got pred=%b idx=%0d ghr=%b expected 0/3/00000",
               prediction, pred_index, pred_ghr);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 5'd7, 1, 0, 0);
      if (i >= 2) begin
        n_total++;
        if (dut.ctr_q[7] !== 2'b11)
          $display("FAIL sat_up_%0d: got %b expected 11", i, dut.ctr_q[7]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 5'd7, 0, 0, 0);
      if (i >= 3) begin
        n_total++;
        if (dut.ctr_q[7] !== 2'b00)
          $display("FAIL sat_down_%0d: got %b expected 00", i, dut.ctr_q[7]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_spec_history();
    step(1, 0, 0, 1, 5'd4, 1, 0, 0);
    step(1, 0, 0, 1, 5'd4, 1, 0, 0);
    step(1, 0, 0, 1, 5'd20, 0, 1, 5'd0);   // force history to zero
    step(1, 1, 5'd4, 0, 0, 0, 0, 0);
    n_total++;
    if (prediction !== 1'b1 || pred_index !== 5'd4 || pred_ghr !== 5'd0)
      $display("FAIL spec_first: got pred=%b idx=%0d ghr=%b expected 1/4/00000",
               prediction, pred_index, pred_ghr);
    else n_pass++;
    step(1, 1, 5'd4, 0, 0, 0, 0, 0);
    n_total++;
    if (pred_index !== 5'd5 || pred_ghr !== 5'b00001)
      $display("FAIL spec_second: got idx=%0d ghr=%b expected 5/00001", pred_index, pred_ghr);
    else n_pass++;
  endtask

  task automatic test_recovery();
    step(1, 1, 5'd2, 1, 5'd1, 0, 1, 5'b10110);
    step(1, 1, 5'd0, 0, 0, 0, 0, 0);
    n_total++;
    if (pred_ghr !== 5'b01100)
      $display("FAIL recovery_ghr: got %b expected 01100", pred_ghr);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [4:0] pc;
    pc = 5'd9 ^ m_ghr;
    step(1, 1, pc, 1, 5'd9, 1, 0, 0);
    n_total++;
    if (prediction !== 1'b0 || pred_index !== 5'd9)
      $display("FAIL collision_lookup: got pred=%b idx=%0d expected 0/9", prediction, pred_index);
    else n_pass++;
    n_total++;
    if (dut.ctr_q[9] !== 2'd2)
      $display("FAIL collision_counter: got %b expected 10", dut.ctr_q[9]);
    else n_pass++;
  endtask

  task automatic test_ignore_and_stall();
    step(1, 0, 0, 0, 5'd9, 1, 1, 5'b11111);  // mispredict without valid
    step(0, 1, 5'd9, 1, 5'd9, 1, 1, 5'b11111);
    n_total++;
    if (dut.ctr_q[9] !== 2'd2)
      $display("FAIL stall_counter: got %b expected 10", dut.ctr_q[9]);
    else n_pass++;
    step(1, 1, 5'd6, 0, 0, 0, 0, 0);          // history must be untouched
  endtask

  task automatic test_count_saturation();
    en = 1'b1; update_valid = 1'b1; update_mispredict = 1'b1;
    update_index = 5'd0; update_taken = 1'b0; update_ghr = '0;
    for (int i = 0; i < 65536; i++) @(posedge clk);
    #1;
    idle_inputs();
    m_cnt = 16'hFFFF; m_ghr = '0; m_tab[0] = 2'd0;
    n_total++;
    if (mispredict_count !== 16'hFFFF)
      $display("FAIL count_saturate: got %h expected ffff", mispredict_count);
    else n_pass++;
    step(1, 0, 0, 1, 5'd0, 0, 1, 0);
    n_total++;
    if (mispredict_count !== 16'hFFFF)
      $display("FAIL count_hold: got %h expected ffff", mispredict_count);
    else n_pass++;
  endtask

  task automatic test_midop_reset();
    en = 1'b1; update_valid = 1'b1; update_index = 5'd12;
    update_taken = 1'b1; update_mispredict = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 5'd4;
    #3 arst = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    arst = 1'b0;
    model_reset();
    n_total++;
    if (dut.ctr_q[12] !== 2'd1 || mispredict_count !== 16'd0 || prediction !== 1'b0)
      $display("FAIL midop_reset: got ctr=%b cnt=%h pred=%b expected 01/0000/0",
               dut.ctr_q[12], mispredict_count, prediction);
    else n_pass++;
    step(1, 1, 5'd12, 0, 0, 0, 0, 0);
  endtask

  initial begin
    arst = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_saturation();
    test_spec_history();
    test_recovery();
    test_collision();
    test_ignore_and_stall();
    test_count_saturation();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 5, meaning log2 of table entries (32 entries).
REQ-002 SHALL have parameter CTR_W, default 2, meaning saturating counter width, legal range 1..4.
REQ-003 SHALL have parameter GHR_W, default 5, meaning global history length, legal range 1..INDEX_W.
REQ-004 SHALL have parameter MODE, default 1, meaning 0 = bimodal (index = pc) and 1 = gshare (index = pc XOR history).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port arst, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit, meaning stage enable; when low, all state and outputs hold.
REQ-008 SHALL have port lookup_valid, input, 1 bit, meaning a lookup request this cycle.
REQ-009 SHALL have port lookup_pc, input, INDEX_W bits, meaning the word-aligned low PC bits.
REQ-010 SHALL have port prediction, output, 1 bit, meaning the registered taken/not-taken prediction.
REQ-011 SHALL have port pred_index, output, INDEX_W bits, meaning the registered table index used, carried down the pipeline.
REQ-012 SHALL have port pred_ghr, output, GHR_W bits, meaning the registered pre-lookup history snapshot.
REQ-013 SHALL have port update_valid, input, 1 bit, meaning a branch resolved this cycle.
REQ-014 SHALL have port update_index, input, INDEX_W bits, meaning the returned pred_index.
REQ-015 SHALL have port update_taken, input, 1 bit, meaning the actual outcome.
REQ-016 SHALL have port update_mispredict, input, 1 bit, meaning prediction and outcome differed.
REQ-017 SHALL have port update_ghr, input, GHR_W bits, meaning the returned pred_ghr.
REQ-018 SHALL have port mispredict_count, output, 16 bits, meaning the saturating mispredict counter.

Function
REQ-019 SHALL form the index as lookup_pc XOR zero-extended GHR in MODE 1, and as lookup_pc in MODE 0.
REQ-020 SHALL register prediction (counter MSB at index), pred_index and pred_ghr one cycle after en & lookup_valid; otherwise these outputs hold.
REQ-021 SHALL, on en & lookup_valid, speculatively shift GHR left by one, inserting the predicted bit at bit 0.
REQ-022 SHALL, on en & update_valid, increment the counter at update_index if taken, else decrement it, saturating at all-ones and zero.
REQ-023 SHALL, on en & update_valid & update_mispredict, load GHR with {update_ghr[GHR_W-2:0], update_taken}, overriding any same-cycle speculative shift; for GHR_W=1, GHR = update_taken.
REQ-024 SHALL, when lookup and update hit the same index in one cycle, give the lookup the pre-update counter value (no bypass).
REQ-025 SHALL increment mispredict_count on each en & update_valid & update_mispredict, holding at 16'hFFFF.
REQ-026 SHALL ignore update_mispredict when update_valid is low.

Reset
REQ-027 SHALL, on arst, immediately set every counter to weakly-not-taken (2^(CTR_W-1)-1; 0 when CTR_W=1), and set GHR, prediction, pred_index, pred_ghr and mispredict_count to 0.
REQ-028 SHALL abandon any in-flight lookup or update when arst asserts mid-operation, with no partial write.

Structure
REQ-029 SHALL place the mode constants (BP_BIMODAL=0, BP_GSHARE=1) and the counter-reset function in shared package bp_pkg.
REQ-030 SHALL implement saturating next-value logic in one combinational sub-module, sat_counter (inputs value and dir; output next value).
REQ-031 SHALL hold the table as a flop array of 2^INDEX_W x CTR_W bits, not inferred RAM.

Verification (INDEX_W=5, CTR_W=2, GHR_W=5, MODE=1)
REQ-032 SHALL cover reset: after arst, lookup pc=3 -> next cycle prediction=0, pred_index=3, pred_ghr=0.
REQ-033 SHALL cover saturation: three taken updates at index 7 -> counter 2'b11; a fourth holds it at 3; four not-taken updates -> 0, and a fifth holds it at 0.
REQ-034 SHALL cover speculative history: GHR=0, counter[4]=3; lookup pc=4 -> prediction=1, GHR=5'b00001; next lookup pc=4 indexes 5.
REQ-035 SHALL cover recovery: a same-cycle lookup plus a mispredict update with update_ghr=5'b10110 and taken=0 -> GHR=5'b01100.
REQ-036 SHALL cover collision: a same-cycle lookup and taken update at index 9 with counter=1 -> prediction=0, counter becomes 2.
REQ-037 SHALL cover stall and count: with en=0, lookup and update inputs -> no state change; 65536 mispredicts -> mispredict_count=16'hFFFF and it holds.
